// File: rtl/fpnew_pipe_out.sv
// ---------------------------------------------------------------------------
// fpnew_pipe_out
//
// Output-side elastic pipeline of an FPU operation group. Carries results
// from the operation-unit datapath towards the issue/arbiter side through
// NumPipeRegs register stages. It uses a valid/ready handshake, collapses
// bubbles and has a synchronous flush.
//
// Optional feature (compile-time macro FPNEW_PIPE_OUT_SKID_EN):
//   A 2-entry FIFO is appended after the last stage. Its ready is taken
//   from registered state only, so out_ready_i has no combinational path
//   to in_ready_o. Latency grows by one cycle.
//
// Parameters
//   Width        result width in bits
//   NumPipeRegs  number of register stages (0 = combinational feed-through)
//   TagType      opaque operation tag type
//   AuxType      opaque auxiliary sideband type
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   result_i, status_i, extension_bit_i, tag_i, aux_i
//                       payload from the datapath
//   in_valid_i / in_ready_o    upstream handshake
//   flush_i             kills every in-flight item at the next edge
//   result_o, status_o, extension_bit_o, tag_o, aux_o
//                       payload towards the arbiter
//   out_valid_o / out_ready_i  downstream handshake
//   busy_o              any valid item at the input, in a stage or in the FIFO
// ---------------------------------------------------------------------------
module fpnew_pipe_out #(
    parameter int unsigned Width       = 32,
    parameter int unsigned NumPipeRegs = 0,
    parameter type         TagType     = logic,
    parameter type         AuxType     = logic
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] result_i,
    input  logic [4:0]       status_i,
    input  logic             extension_bit_i,
    input  TagType           tag_i,
    input  AuxType           aux_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             flush_i,
    output logic [Width-1:0] result_o,
    output logic [4:0]       status_o,
    output logic             extension_bit_o,
    output TagType           tag_o,
    output AuxType           aux_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o
);

    // End of the register chain (or the raw inputs when there are no stages).
    logic             pipe_vld;
    logic [Width-1:0] pipe_res;
    logic [4:0]       pipe_st;
    logic             pipe_ext;
    TagType           pipe_tag;
    AuxType           pipe_aux;
    logic             pipe_rdy;
    logic             stage_busy;
    logic             skid_busy;

    generate
        if (NumPipeRegs == 0) begin : g_nopipe
            // Pure feed-through. Clock, reset and flush have nothing to act on.
            logic unused_ctrl;
            assign unused_ctrl = ^{clk_i, rst_i, flush_i};

            assign pipe_vld   = in_valid_i;
            assign pipe_res   = result_i;
            assign pipe_st    = status_i;
            assign pipe_ext   = extension_bit_i;
            assign pipe_tag   = tag_i;
            assign pipe_aux   = aux_i;
            assign in_ready_o = pipe_rdy;
            assign stage_busy = 1'b0;
        end else begin : g_pipe
            localparam int unsigned N = NumPipeRegs;

            // Bit k of vld_q / entry k of the data arrays hold stage k+1.
            // rdy[k] is the ready seen by stage k (the input side of register k).
            logic [N-1:0]     vld_q;
            logic [N-1:0]     rdy;
            logic [Width-1:0] res_q [N];
            logic [4:0]       st_q  [N];
            logic             ext_q [N];
            TagType           tag_q [N];
            AuxType           aux_q [N];

            // The ripple ready[s] = ready[s+1] | ~valid[s+1] is unrolled here.
            // A stage may advance when the sink is ready or when any stage
            // downstream of it holds a bubble that can be filled.
            for (genvar k = 0; k < N; k++) begin : g_rdy
                assign rdy[k] = pipe_rdy | ~(&vld_q[N-1:k]);
            end

            always_ff @(posedge clk_i or posedge rst_i) begin : p_vld
                if (rst_i) begin
                    vld_q <= '0;
                end else if (flush_i) begin
                    vld_q <= '0;
                end else begin
                    if (rdy[0]) vld_q[0] <= in_valid_i;
                    for (int k = 1; k < N; k++) begin
                        if (rdy[k]) vld_q[k] <= vld_q[k-1];
                    end
                end
            end

            // Data registers load only when a valid item actually moves in.
            always_ff @(posedge clk_i or posedge rst_i) begin : p_data
                if (rst_i) begin
                    for (int k = 0; k < N; k++) begin
                        res_q[k] <= '0;
                        st_q[k]  <= '0;
                        ext_q[k] <= 1'b0;
                        tag_q[k] <= '0;
                        aux_q[k] <= '0;
                    end
                end else begin
                    if (rdy[0] && in_valid_i) begin
                        res_q[0] <= result_i;
                        st_q[0]  <= status_i;
                        ext_q[0] <= extension_bit_i;
                        tag_q[0] <= tag_i;
                        aux_q[0] <= aux_i;
                    end
                    for (int k = 1; k < N; k++) begin
                        if (rdy[k] && vld_q[k-1]) begin
                            res_q[k] <= res_q[k-1];
                            st_q[k]  <= st_q[k-1];
                            ext_q[k] <= ext_q[k-1];
                            tag_q[k] <= tag_q[k-1];
                            aux_q[k] <= aux_q[k-1];
                        end
                    end
                end
            end

            assign pipe_vld   = vld_q[N-1];
            assign pipe_res   = res_q[N-1];
            assign pipe_st    = st_q[N-1];
            assign pipe_ext   = ext_q[N-1];
            assign pipe_tag   = tag_q[N-1];
            assign pipe_aux   = aux_q[N-1];
            assign in_ready_o = rdy[0];
            assign stage_busy = |vld_q;
        end
    endgenerate

`ifdef FPNEW_PIPE_OUT_SKID_EN
    // 2-entry FIFO behind the last stage. Ready towards the stages depends
    // only on the registered occupancy, which cuts the out_ready_i path.
    logic [1:0]       cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic             rd_q, rd_d;
    logic             push, pop;
    logic [Width-1:0] mem_res [2];
    logic [4:0]       mem_st  [2];
    logic             mem_ext [2];
    TagType           mem_tag [2];
    AuxType           mem_aux [2];

    assign pipe_rdy    = ~cnt_q[1];
    assign push        = pipe_vld & pipe_rdy;
    assign out_valid_o = (cnt_q != 2'd0);
    assign pop         = out_valid_o & out_ready_i;
    assign skid_busy   = out_valid_o;

    always_comb begin : p_skid_next
        cnt_d = cnt_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push && !pop) cnt_d = cnt_q + 2'd1;
        else if (!push && pop) cnt_d = cnt_q - 2'd1;
        if (push) wr_d = ~wr_q;
        if (pop)  rd_d = ~rd_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin : p_skid_ctrl
        if (rst_i) begin
            cnt_q <= 2'd0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
        end else if (flush_i) begin
            cnt_q <= 2'd0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin : p_skid_data
        if (rst_i) begin
            for (int k = 0; k < 2; k++) begin
                mem_res[k] <= '0;
                mem_st[k]  <= '0;
                mem_ext[k] <= 1'b0;
                mem_tag[k] <= '0;
                mem_aux[k] <= '0;
            end
        end else if (push) begin
            mem_res[wr_q] <= pipe_res;
            mem_st[wr_q]  <= pipe_st;
            mem_ext[wr_q] <= pipe_ext;
            mem_tag[wr_q] <= pipe_tag;
            mem_aux[wr_q] <= pipe_aux;
        end
    end

    assign result_o        = mem_res[rd_q];
    assign status_o        = mem_st[rd_q];
    assign extension_bit_o = mem_ext[rd_q];
    assign tag_o           = mem_tag[rd_q];
    assign aux_o           = mem_aux[rd_q];
`else
    assign pipe_rdy        = out_ready_i;
    assign out_valid_o     = pipe_vld;
    assign result_o        = pipe_res;
    assign status_o        = pipe_st;
    assign extension_bit_o = pipe_ext;
    assign tag_o           = pipe_tag;
    assign aux_o           = pipe_aux;
    assign skid_busy       = 1'b0;
`endif

    assign busy_o = in_valid_i | stage_busy | skid_busy;

endmodule

// File: tb/tb_fpnew_pipe_out.sv
module tb_fpnew_pipe_out;

    localparam int W  = 32;
    localparam int N2 = 2;

    typedef logic [7:0] tag_t;
    typedef logic [2:0] aux_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Shared payload inputs
    logic [W-1:0] res_in = '0;
    logic [4:0]   st_in  = '0;
    logic         ext_in = 1'b0;
    tag_t         tag_in = '0;
    aux_t         aux_in = '0;

    // Per-instance control and outputs
    logic v2 = 0, r2 = 0, f2 = 0, rdy2, ov2, ext2, busy2;
    logic [W-1:0] res2; logic [4:0] st2; tag_t tag2; aux_t aux2;
    logic v3 = 0, r3 = 0, f3 = 0, rdy3, ov3, ext3, busy3;
    logic [W-1:0] res3; logic [4:0] st3; tag_t tag3; aux_t aux3;
    logic v1 = 0, r1 = 0, f1 = 0, rdy1, ov1, ext1, busy1;
    logic [W-1:0] res1; logic [4:0] st1; tag_t tag1; aux_t aux1;

    logic unused_sink;
    assign unused_sink = ^{res3, st3, ext3, aux3, busy3, res1, st1, ext1, aux1, f3};

    fpnew_pipe_out #(.Width(W), .NumPipeRegs(2), .TagType(tag_t), .AuxType(aux_t)) dut2 (
        .clk_i(clk), .rst_i(rst), .result_i(res_in), .status_i(st_in),
        .extension_bit_i(ext_in), .tag_i(tag_in), .aux_i(aux_in),
        .in_valid_i(v2), .in_ready_o(rdy2), .flush_i(f2),
        .result_o(res2), .status_o(st2), .extension_bit_o(ext2), .tag_o(tag2),
        .aux_o(aux2), .out_valid_o(ov2), .out_ready_i(r2), .busy_o(busy2));

    fpnew_pipe_out #(.Width(W), .NumPipeRegs(3), .TagType(tag_t), .AuxType(aux_t)) dut3 (
        .clk_i(clk), .rst_i(rst), .result_i(res_in), .status_i(st_in),
        .extension_bit_i(ext_in), .tag_i(tag_in), .aux_i(aux_in),
        .in_valid_i(v3), .in_ready_o(rdy3), .flush_i(f3),
        .result_o(res3), .status_o(st3), .extension_bit_o(ext3), .tag_o(tag3),
        .aux_o(aux3), .out_valid_o(ov3), .out_ready_i(r3), .busy_o(busy3));

    fpnew_pipe_out #(.Width(W), .NumPipeRegs(1), .TagType(tag_t), .AuxType(aux_t)) dut1 (
        .clk_i(clk), .rst_i(rst), .result_i(res_in), .status_i(st_in),
        .extension_bit_i(ext_in), .tag_i(tag_in), .aux_i(aux_in),
        .in_valid_i(v1), .in_ready_o(rdy1), .flush_i(f1),
        .result_o(res1), .status_o(st1), .extension_bit_o(ext1), .tag_o(tag1),
        .aux_o(aux1), .out_valid_o(ov1), .out_ready_i(r1), .busy_o(busy1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    // Reference model of the NumPipeRegs=2 instance: an ordered list of
    // in-flight items, each with its depth (1..N2) in the pipe. An item moves
    // one place per cycle unless the item ahead of it blocks it; the head is
    // offered downstream once it reaches depth N2. The input is accepted when
    // the sink is ready or fewer than N2 items are in flight.
    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   st;
        logic         ext;
        tag_t         tag;
        aux_t         aux;
        int           pos;
    } item_t;

    item_t q2[$];
    logic  e2_rdy, e2_vld;

    task automatic check2(input string nm);
        #1;
        e2_rdy = r2 || (q2.size() < N2);
        e2_vld = (q2.size() > 0) && (q2[0].pos == N2);
        chk({nm, ".in_ready"}, rdy2, e2_rdy);
        chk({nm, ".out_valid"}, ov2, e2_vld);
        chk({nm, ".busy"}, busy2, v2 || (q2.size() > 0));
        if (e2_vld) begin
            chk({nm, ".result"}, res2, q2[0].res);
            chk({nm, ".tag"}, tag2, q2[0].tag);
            chk({nm, ".status"}, st2, q2[0].st);
            chk({nm, ".ext"}, ext2, q2[0].ext);
            chk({nm, ".aux"}, aux2, q2[0].aux);
        end
    endtask

    task automatic adv2();
        item_t it;
        @(posedge clk);
        if (rst || f2) begin
            q2.delete();
        end else begin
            if (e2_vld && r2) void'(q2.pop_front());
            for (int i = 0; i < q2.size(); i++) begin
                int lim;
                lim = (i == 0) ? N2 : q2[i-1].pos - 1;
                q2[i].pos = (q2[i].pos + 1 < lim) ? q2[i].pos + 1 : lim;
            end
            if (v2 && e2_rdy) begin
                it.res = res_in; it.st = st_in; it.ext = ext_in;
                it.tag = tag_in; it.aux = aux_in; it.pos = 1;
                q2.push_back(it);
            end
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_item(input logic [W-1:0] r, input tag_t t);
        res_in = r;
        tag_in = t;
        st_in  = 5'($urandom);
        ext_in = 1'($urandom);
        aux_in = 3'($urandom);
    endtask

    initial begin
        int first;
        int nvld;
        int seen7;

        // Reset state, with reset held across clock edges
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", ov2, 1'b0);
        chk("rst.result", res2, 32'h0);
        chk("rst.tag", tag2, 8'h0);
        chk("rst.in_ready", rdy2, 1'b1);
        chk("rst.busy_idle", busy2, 1'b0);
        v2 = 1'b1;
        #1;
        chk("rst.busy_in_valid", busy2, 1'b1);
        v2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();

`ifndef FPNEW_PIPE_OUT_SKID_EN
        // Back-to-back stream, sink always ready
        r2 = 1'b1;
        first = -1;
        nvld = 0;
        for (int c = 0; c < 10; c++) begin
            if (c < 5) begin
                v2 = 1'b1;
                set_item(32'h3F80_0000 + 32'(c), tag_t'(c + 1));
            end else begin
                v2 = 1'b0;
            end
            check2("stream");
            if (ov2) begin
                if (first < 0) first = c;
                nvld++;
            end
            adv2();
        end
        chk("stream.latency", first, 2);
        chk("stream.valid_cycles", nvld, 5);

        // One item held under a stalled sink
        r2 = 1'b0;
        v2 = 1'b1;
        set_item(32'hC0DE_0001, 8'h20);
        check2("hold");
        adv2();
        v2 = 1'b0;
        for (int c = 1; c < 7; c++) begin
            check2("hold");
            adv2();
        end
        chk("hold.result", res2, 32'hC0DE_0001);
        chk("hold.tag", tag2, 8'h20);
        v2 = 1'b1;
        set_item(32'hC0DE_0002, 8'h21);
        check2("hold2");
        adv2();
        v2 = 1'b0;
        check2("hold2");
        chk("hold.full_in_ready", rdy2, 1'b0);
        adv2();
        r2 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check2("drain");
            adv2();
        end

        // NumPipeRegs=3: fill while stalled, then release
        r3 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            v3 = 1'b1;
            set_item(32'h1000 + 32'(c), tag_t'(c + 1));
            check2("idle");
            chk("fill3.in_ready", rdy3, 1'b1);
            adv2();
        end
        v3 = 1'b0;
        check2("idle");
        chk("fill3.full_in_ready", rdy3, 1'b0);
        chk("fill3.out_valid", ov3, 1'b1);
        chk("fill3.head_tag", tag3, 8'd1);
        adv2();
        r3 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check2("idle");
            chk("drain3.out_valid", ov3, 1'b1);
            chk("drain3.tag", tag3, tag_t'(c + 1));
            adv2();
        end
        check2("idle");
        chk("drain3.empty", ov3, 1'b0);
        adv2();

        // Flush with two items in flight and a new item offered
        r2 = 1'b0;
        v2 = 1'b1;
        set_item(32'hAAAA_0001, 8'h11);
        check2("flush");
        adv2();
        set_item(32'hAAAA_0002, 8'h12);
        check2("flush");
        adv2();
        f2 = 1'b1;
        set_item(32'hAAAA_0007, 8'h07);
        check2("flush");
        adv2();
        f2 = 1'b0;
        set_item(32'hAAAA_0009, 8'h09);
        check2("postflush");
        chk("flush.out_valid", ov2, 1'b0);
        chk("flush.busy", busy2, 1'b1);
        adv2();
        v2 = 1'b0;
        r2 = 1'b1;
        seen7 = 0;
        for (int c = 0; c < 6; c++) begin
            check2("postflush");
            if (ov2 && tag2 == 8'h07) seen7++;
            adv2();
        end
        chk("flush.tag7_absent", seen7, 0);

        // Asynchronous reset in the middle of a stream
        r2 = 1'b0;
        v2 = 1'b1;
        set_item(32'hBBBB_0001, 8'h31);
        check2("areset");
        adv2();
        set_item(32'hBBBB_0002, 8'h32);
        check2("areset");
        adv2();
        v2 = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("areset.out_valid", ov2, 1'b0);
        chk("areset.result", res2, 32'h0);
        chk("areset.in_ready", rdy2, 1'b1);
        chk("areset.busy", busy2, 1'b0);
        q2.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();
        r2 = 1'b1;
        first = -1;
        for (int c = 0; c < 5; c++) begin
            v2 = (c == 0);
            set_item(32'hBBBB_0033, 8'h33);
            check2("after_reset");
            if (ov2 && first < 0) first = c;
            adv2();
        end
        chk("after_reset.latency", first, 2);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            v2 = ($urandom_range(0, 9) < 7);
            r2 = ($urandom_range(0, 9) < 6);
            f2 = ($urandom_range(0, 31) == 0);
            set_item(32'($urandom), tag_t'($urandom));
            check2("rand");
            adv2();
        end
        f2 = 1'b0;
        v2 = 1'b0;

        chk("idle1.out_valid", ov1, 1'b0);
        chk("idle1.busy", busy1, 1'b0);
`else
        // NumPipeRegs=1 with skid FIFO: latency
        r1 = 1'b1;
        v1 = 1'b1;
        set_item(32'h4100_0000, 8'h41);
        #1;
        chk("skid.in_ready0", rdy1, 1'b1);
        chk("skid.out_valid0", ov1, 1'b0);
        tick();
        v1 = 1'b0;
        #1;
        chk("skid.out_valid1", ov1, 1'b0);
        chk("skid.busy1", busy1, 1'b1);
        tick();
        chk("skid.out_valid2", ov1, 1'b1);
        chk("skid.tag2", tag1, 8'h41);
        chk("skid.result2", res1, 32'h4100_0000);
        tick();
        chk("skid.out_valid3", ov1, 1'b0);

        // Stalled sink: three items buffered, fourth refused
        r1 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            v1 = 1'b1;
            set_item(32'h5000 + 32'(c), tag_t'(8'h50 + c));
            #1;
            chk("skid.fill_in_ready", rdy1, (c < 3));
            if (c < 3) tick();
        end
        chk("skid.fill_head", tag1, 8'h50);
        r1 = 1'b1;
        #1;
        chk("skid.no_comb_ready", rdy1, 1'b0);
        tick();
        chk("skid.reopen", rdy1, 1'b1);
        chk("skid.order1", tag1, 8'h51);
        tick();
        v1 = 1'b0;
        #1;
        chk("skid.order2", tag1, 8'h52);
        tick();
        chk("skid.order3", tag1, 8'h53);
        tick();
        chk("skid.drained", ov1, 1'b0);
        chk("skid.drained_busy", busy1, 1'b0);

        // Flush clears stages and FIFO
        r1 = 1'b0;
        v1 = 1'b1;
        set_item(32'h6000, 8'h60);
        tick();
        v1 = 1'b0;
        f1 = 1'b1;
        tick();
        f1 = 1'b0;
        #1;
        chk("skid.flush_valid", ov1, 1'b0);
        chk("skid.flush_busy", busy1, 1'b0);
        tick();
        chk("skid.flush_valid2", ov1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
